// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, FSM encoding, byte indexing and S-box tables.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte k of the state lives at bits [(15-k)*8 +: 8]; byte 0 is the MSB.
  function automatic int unsigned byte_lsb(input int unsigned k);
    return (AES_BYTES - 1 - k) * 8;
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Inverse AES S-box: 8-bit combinational table lookup.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y_c
);

  assign y_c = INV_SBOX[a];

endmodule

// File: rtl/sbox.sv
// Forward AES S-box: 8-bit combinational table lookup shared with the encryption path.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y_c
);

  assign y_c = SBOX[a];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes: LANES bytes per cycle over NCYC = 16/LANES cycles.
// Optional lane self-check (forward S-box recompute) enabled by INV_SUB_BYTES_SELFCHECK_EN.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy,
  output logic                   sbox_err
);

  localparam int unsigned NCYC = AES_BYTES / LANES;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int unsigned LW   = LANES * 8;
  localparam int unsigned LIW  = $clog2(LW);
  localparam int unsigned BIW  = $clog2(AES_STATE_W);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic [AES_STATE_W-1:0] out_q, out_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic [LW-1:0]          src_c;
  logic [LW-1:0]          inv_out;
  logic                   accept_c;

  assign accept_c = in_valid & in_ready_q;

  // Gather the bytes selected by the current cycle count into the lane bus.
  always_comb begin
    src_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      src_c[LIW'(l * 8) +: 8] = work_q[BIW'(byte_lsb(32'(cnt_q) * LANES + l)) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv (
      .a   (src_c[l*8 +: 8]),
      .y_c (inv_out[l*8 +: 8])
    );
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_d       = out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          work_d     = in_state;
          cnt_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          out_d[BIW'(byte_lsb(32'(cnt_q) * LANES + l)) +: 8] = inv_out[LIW'(l * 8) +: 8];
        end
        if (cnt_q == CW'(NCYC - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, datapath and handshake registers; reset drops any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_q;
  assign busy      = busy_q;

`ifdef INV_SUB_BYTES_SELFCHECK_EN
  logic [LW-1:0] fwd_c;
  logic          mis_c;
  logic          chk_q;
  logic          err_q;

  for (genvar l = 0; l < LANES; l++) begin : g_chk
    sbox u_fwd (
      .a   (inv_out[l*8 +: 8]),
      .y_c (fwd_c[l*8 +: 8])
    );
  end

  assign mis_c = (state_q == RUN) && (fwd_c != src_c);

  // Mismatch of a written lane is staged one cycle, then latched sticky until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept_c) begin
      chk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      chk_q <= mis_c;
      err_q <= err_q | chk_q;
    end
  end

  assign sbox_err = err_q;
`else
  assign sbox_err = 1'b0;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter at LANES = 4 (idx 0), 1 (idx 1) and 16 (idx 2).
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic         sbox_err  [3];
  logic [127:0] in_state  [3];
  logic [127:0] out_state [3];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] VEC_A     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_A_INV = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] VEC_B     = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] VEC_B_INV = 128'h7ce339829b2fff87348e4344c4dee9cb;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]), .busy(busy[0]), .sbox_err(sbox_err[0])
  );

  inv_sub_bytes_iter #(.LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]), .busy(busy[1]), .sbox_err(sbox_err[1])
  );

  inv_sub_bytes_iter #(.LANES(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_state(out_state[2]), .busy(busy[2]), .sbox_err(sbox_err[2])
  );

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Push one block into instance i with out_ready high, check latency, result and drain.
  task automatic run_block(input int i, input logic [127:0] st, input logic [127:0] exp,
                           input int ncyc, input string tag);
    int lat;
    in_state[i]  = st;
    in_valid[i]  = 1'b1;
    out_ready[i] = 1'b1;
    wait_edge();
    in_valid[i] = 1'b0;
    n_cmp++;
    if (busy[i] !== 1'b1) begin
      n_bad++; $display("FAIL %s busy_after_accept: got %b want 1", tag, busy[i]);
    end
    lat = 0;
    while (out_valid[i] !== 1'b1 && lat < 40) begin
      n_cmp++;
      if (in_ready[i] !== 1'b0) begin
        n_bad++; $display("FAIL %s in_ready_run: got %b want 0", tag, in_ready[i]);
      end
      wait_edge();
      lat++;
    end
    n_cmp++;
    if (lat != ncyc) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, ncyc);
    end
    n_cmp++;
    if (out_state[i] !== exp) begin
      n_bad++; $display("FAIL %s out_state: got %h want %h", tag, out_state[i], exp);
    end
    n_cmp++;
    if (in_ready[i] !== 1'b0) begin
      n_bad++; $display("FAIL %s in_ready_done: got %b want 0", tag, in_ready[i]);
    end
    wait_edge();
    n_cmp++;
    if ({out_valid[i], in_ready[i], busy[i]} !== 3'b010) begin
      n_bad++; $display("FAIL %s drain: got v/r/b=%b%b%b want 010", tag,
                        out_valid[i], in_ready[i], busy[i]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_state[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({in_ready[i], out_valid[i], busy[i], sbox_err[i]} !== 4'b1000) begin
        n_bad++; $display("FAIL reset_ctl[%0d]: got r/v/b/e=%b%b%b%b want 1000", i,
                          in_ready[i], out_valid[i], busy[i], sbox_err[i]);
      end
      n_cmp++;
      if (out_state[i] !== 128'h0) begin
        n_bad++; $display("FAIL reset_state[%0d]: got %h want 0", i, out_state[i]);
      end
    end
    #3 rst_n = 1'b1;
    wait_edge();
  endtask

  task automatic test_lanes4();
    run_block(0, {16{8'h63}}, {16{8'h00}}, 4, "l4_63");
    run_block(0, VEC_A, VEC_A_INV, 4, "l4_vecA");
  endtask

  task automatic test_lanes1();
    run_block(1, 128'h0, {16{8'h52}}, 16, "l1_zero");
    run_block(1, {8'h16, {14{8'h63}}, 8'h7c}, {8'hff, {14{8'h00}}, 8'h01}, 16, "l1_edges");
  endtask

  task automatic test_backpressure();
    int lat;
    in_state[0]  = VEC_A;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    wait_edge();
    in_state[0] = VEC_B;
    lat = 0;
    while (out_valid[0] !== 1'b1 && lat < 40) begin
      wait_edge();
      lat++;
    end
    n_cmp++;
    if (lat != 4) begin
      n_bad++; $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int c = 0; c < 10; c++) begin
      wait_edge();
      n_cmp++;
      if (out_state[0] !== VEC_A_INV || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold cyc%0d: got v=%b r=%b %h want v=1 r=0 %h", c,
                          out_valid[0], in_ready[0], out_state[0], VEC_A_INV);
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    wait_edge();
    n_cmp++;
    if ({out_valid[0], in_ready[0], busy[0]} !== 3'b010) begin
      n_bad++; $display("FAIL bp_release: got v/r/b=%b%b%b want 010",
                        out_valid[0], in_ready[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    in_state[0]  = 128'h0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    wait_edge();
    in_valid[0] = 1'b0;
    wait_edge();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid[0], in_ready[0], busy[0]} !== 3'b010) begin
      n_bad++; $display("FAIL midrst_ctl: got v/r/b=%b%b%b want 010",
                        out_valid[0], in_ready[0], busy[0]);
    end
    n_cmp++;
    if (out_state[0] !== 128'h0) begin
      n_bad++; $display("FAIL midrst_state: got %h want 0", out_state[0]);
    end
    #1 rst_n = 1'b1;
    wait_edge();
    run_block(0, VEC_A, VEC_A_INV, 4, "after_rst");
  endtask

  task automatic test_back_to_back();
    int first_c;
    int second_c;
    first_c  = -1;
    second_c = -1;
    in_state[2]  = VEC_A;
    in_valid[2]  = 1'b1;
    out_ready[2] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      wait_edge();
      if (c == 1) in_state[2] = VEC_B;
      if (out_valid[2] === 1'b1) begin
        if (first_c < 0) begin
          first_c = c;
          n_cmp++;
          if (out_state[2] !== VEC_A_INV) begin
            n_bad++; $display("FAIL b2b_first: got %h want %h", out_state[2], VEC_A_INV);
          end
        end else if (second_c < 0) begin
          second_c = c;
          in_valid[2] = 1'b0;
          n_cmp++;
          if (out_state[2] !== VEC_B_INV) begin
            n_bad++; $display("FAIL b2b_second: got %h want %h", out_state[2], VEC_B_INV);
          end
        end
      end
    end
    in_valid[2] = 1'b0;
    n_cmp++;
    if (first_c != 2) begin
      n_bad++; $display("FAIL b2b_first_cycle: got %0d want 2", first_c);
    end
    n_cmp++;
    if (second_c - first_c != 3) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d want 3", second_c - first_c);
    end
  endtask

  task automatic test_selfcheck();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (sbox_err[i] !== 1'b0) begin
        n_bad++; $display("FAIL sbox_err_clean[%0d]: got %b want 0", i, sbox_err[i]);
      end
    end
`ifdef INV_SUB_BYTES_SELFCHECK_EN
    force u4.inv_out = 32'h0;
    in_state[0]  = 128'h0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    wait_edge();
    in_valid[0] = 1'b0;
    repeat (2) wait_edge();
    n_cmp++;
    if (sbox_err[0] !== 1'b1) begin
      n_bad++; $display("FAIL sbox_err_set: got %b want 1", sbox_err[0]);
    end
    repeat (4) wait_edge();
    release u4.inv_out;
    out_ready[0] = 1'b1;
    wait_edge();
    n_cmp++;
    if (sbox_err[0] !== 1'b1 || in_ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL sbox_err_sticky: got e=%b r=%b want e=1 r=1", sbox_err[0], in_ready[0]);
    end
    run_block(0, VEC_A, VEC_A_INV, 4, "chk_clean");
    n_cmp++;
    if (sbox_err[0] !== 1'b0) begin
      n_bad++; $display("FAIL sbox_err_clear: got %b want 0", sbox_err[0]);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lanes4();
    test_lanes1();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_selfcheck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
